// File: rtl/analog_status_monitor.sv
// APB-readable status block: synchronises N_CH analog status words, flags per-bit
// changes in sticky W1C registers and drives a masked, globally enabled level interrupt.
module analog_status_monitor #(
   parameter int N_CH       = 4,
   parameter int DATA_W     = 32,
   parameter int SYNC_DEPTH = 2
) (
   input  logic                     clk_in,
   input  logic                     reset_n,
   input  logic [11:0]              PADDR,
   input  logic                     PENABLE,
   input  logic                     PSEL,
   input  logic [3:0]               PSTRB,
   input  logic [31:0]              PWDATA,
   input  logic                     PWRITE,
   output logic [31:0]              PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   input  logic [N_CH*DATA_W-1:0]   status_in,
   output logic                     irq
);

   localparam int W = N_CH * DATA_W;

   // APB handshake: an access is accepted on the edge where PSEL & PENABLE & ~PREADY;
   // that same edge raises PREADY for exactly one cycle with PRDATA/PSLVERR valid.

   logic [W-1:0]  sync_q [SYNC_DEPTH];
   logic [W-1:0]  sync_d [SYNC_DEPTH];
   logic [W-1:0]  prev_q, prev_d;
   logic [W-1:0]  sticky_q, sticky_d;
   logic [W-1:0]  mask_q, mask_d;
   logic          ctrl_q, ctrl_d;
   logic          irq_q, irq_d;
   logic [31:0]   prdata_q, prdata_d;
   logic          pready_q, pready_d;
   logic          pslverr_q, pslverr_d;

   logic [W-1:0]  sync_w;
   logic [W-1:0]  chg;
   logic [W-1:0]  w1c;
   logic [31:0]   irq_stat;
   logic [31:0]   sel_sync, sel_sticky, sel_mask;
   logic [31:0]   rdata;
   logic [1:0]    region;
   logic [5:0]    idx;
   logic          access, chan_ok, mapped, read_only, err, wr_ok;

   assign sync_w = sync_q[SYNC_DEPTH-1];
   assign chg    = sync_w ^ prev_q;

   always_comb begin
      sync_d[0] = status_in;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Address decode and read mux
   always_comb begin
      access    = PSEL & PENABLE & ~pready_q;
      region    = PADDR[9:8];
      idx       = PADDR[7:2];
      chan_ok   = (PADDR[11:10] == 2'b00) && (idx < 6'(N_CH));
      sel_sync   = '0;
      sel_sticky = '0;
      sel_mask   = '0;
      irq_stat   = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (idx == 6'(k)) begin
            sel_sync[DATA_W-1:0]   = sync_w[k*DATA_W +: DATA_W];
            sel_sticky[DATA_W-1:0] = sticky_q[k*DATA_W +: DATA_W];
            sel_mask[DATA_W-1:0]   = mask_q[k*DATA_W +: DATA_W];
         end
         irq_stat[k] = |(sticky_q[k*DATA_W +: DATA_W] & mask_q[k*DATA_W +: DATA_W]);
      end
      mapped    = 1'b0;
      read_only = 1'b0;
      rdata     = '0;
      case (region)
         2'd0: begin
            mapped    = chan_ok;
            read_only = 1'b1;
            rdata     = sel_sync;
         end
         2'd1: begin
            mapped = chan_ok;
            rdata  = sel_sticky;
         end
         2'd2: begin
            mapped = chan_ok;
            rdata  = sel_mask;
         end
         default: begin
            mapped    = (PADDR[11:10] == 2'b00) && (idx == 6'd0 || idx == 6'd1);
            read_only = (idx == 6'd0);
            rdata     = (idx == 6'd0) ? irq_stat : {31'b0, ctrl_q};
         end
      endcase
      err   = ~mapped | (PADDR[1:0] != 2'b00) | (PWRITE & (read_only | (PSTRB != 4'hF)));
      wr_ok = access & PWRITE & ~err;
   end

   // Register side effects and next state
   always_comb begin
      w1c    = '0;
      mask_d = mask_q;
      ctrl_d = ctrl_q;
      if (wr_ok) begin
         for (int k = 0; k < N_CH; k++) begin
            if (idx == 6'(k)) begin
               if (region == 2'd1) w1c[k*DATA_W +: DATA_W]    = PWDATA[DATA_W-1:0];
               if (region == 2'd2) mask_d[k*DATA_W +: DATA_W] = PWDATA[DATA_W-1:0];
            end
         end
         if (region == 2'd3 && idx == 6'd1) ctrl_d = PWDATA[0];
      end
      prev_d   = sync_w;
      // A fresh change wins over a simultaneous clear of the same bit
      sticky_d = (sticky_q & ~w1c) | chg;
      irq_d    = ctrl_q & (|irq_stat);

      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = prdata_q;
      if (access) begin
         pready_d  = 1'b1;
         pslverr_d = err;
         if (err)          prdata_d = '0;
         else if (!PWRITE) prdata_d = rdata;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
         prev_q    <= '0;
         sticky_q  <= '0;
         mask_q    <= '1;
         ctrl_q    <= 1'b0;
         irq_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= sync_d[i];
         prev_q    <= prev_d;
         sticky_q  <= sticky_d;
         mask_q    <= mask_d;
         ctrl_q    <= ctrl_d;
         irq_q     <= irq_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_analog_status_monitor.sv
// Self-checking bench for analog_status_monitor: APB driver tasks, a scoreboard
// queue of expected responses and cycle-exact interrupt latency checks.
module tb_analog_status_monitor;

   localparam int N_CH       = 4;
   localparam int DATA_W     = 32;
   localparam int SYNC_DEPTH = 2;

   logic                   clk_in;
   logic                   reset_n;
   logic [11:0]            PADDR;
   logic                   PENABLE;
   logic                   PSEL;
   logic [3:0]             PSTRB;
   logic [31:0]            PWDATA;
   logic                   PWRITE;
   logic [31:0]            PRDATA;
   logic                   PREADY;
   logic                   PSLVERR;
   logic [N_CH*DATA_W-1:0] status_in;
   logic                   irq;

   logic [32:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   analog_status_monitor #(
      .N_CH(N_CH), .DATA_W(DATA_W), .SYNC_DEPTH(SYNC_DEPTH)
   ) dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL), .PSTRB(PSTRB),
      .PWDATA(PWDATA), .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .status_in(status_in), .irq(irq)
   );

   // clock / reset
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // one APB transfer, started just after a rising edge
   task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata, output logic err);
      int waits;
      logic got;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
      @(posedge clk_in); #1;
      PENABLE = 1'b1;
      got   = 1'b0;
      waits = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk_in); #1;
         waits++;
         if (PREADY) got = 1'b1;
      end
      check("pready_seen", 32'(got), 32'd1);
      check("wait_cycles", 32'(waits), 32'd1);
      rdata = PRDATA;
      err   = PSLVERR;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge clk_in); #1;
      check("pready_pulse", 32'(PREADY), 32'd0);
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                     input logic exp_err);
      logic [31:0] d;
      logic        e;
      logic [32:0] x;
      exp_q.push_back({exp_err, exp_data});
      apb_xfer(1'b0, addr, 32'h0, 4'h0, d, e);
      x = exp_q.pop_front();
      check({tag, "_err"}, 32'(e), 32'(x[32]));
      check({tag, "_data"}, d, x[31:0]);
   endtask

   task automatic wr(input string tag, input logic [11:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic exp_err);
      logic [31:0] d;
      logic        e;
      logic [32:0] x;
      exp_q.push_back({exp_err, 32'h0});
      apb_xfer(1'b1, addr, data, strb, d, e);
      x = exp_q.pop_front();
      check({tag, "_err"}, 32'(e), 32'(x[32]));
   endtask

   initial begin
      reset_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0; status_in = '0;
      #1;
      check("rst_prdata", PRDATA, 32'h0);
      check("rst_pready", 32'(PREADY), 32'h0);
      check("rst_pslverr", 32'(PSLVERR), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      repeat (3) @(posedge clk_in);
      #1 reset_n = 1'b1;
      @(posedge clk_in); #1;

      rd("ctrl_rst", 12'h304, 32'h0, 1'b0);
      rd("mask0_rst", 12'h200, 32'hFFFF_FFFF, 1'b0);
      rd("status0_rst", 12'h000, 32'h0, 1'b0);

      // irq latency: sync after SYNC_DEPTH edges, sticky one later, irq one after that
      wr("ctrl_en", 12'h304, 32'h1, 4'hF, 1'b0);
      status_in[32 +: 32] = 32'hA5A5_A5A5;
      for (int i = 1; i <= SYNC_DEPTH + 2; i++) begin
         @(posedge clk_in); #1;
         check($sformatf("irq_lat%0d", i), 32'(irq), 32'(i == SYNC_DEPTH + 2));
      end
      rd("status1", 12'h004, 32'hA5A5_A5A5, 1'b0);
      rd("sticky1", 12'h104, 32'hA5A5_A5A5, 1'b0);
      rd("irqstat_a", 12'h300, 32'h2, 1'b0);

      wr("w1c1", 12'h104, 32'hFFFF_0000, 4'hF, 1'b0);
      rd("sticky1_w1c", 12'h104, 32'h0000_A5A5, 1'b0);
      check("irq_still", 32'(irq), 32'h1);
      wr("mask1", 12'h204, 32'hFFFF_0000, 4'hF, 1'b0);
      check("irq_masked", 32'(irq), 32'h0);
      rd("irqstat_b", 12'h300, 32'h0, 1'b0);
      rd("mask1_rb", 12'h204, 32'hFFFF_0000, 1'b0);

      // change in the same edge as the W1C of that bit
      status_in[0] = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      rd("sticky0_set", 12'h100, 32'h1, 1'b0);
      status_in[0] = 1'b0;
      @(posedge clk_in); #1;
      wr("w1c_race", 12'h100, 32'h1, 4'hF, 1'b0);
      rd("sticky0_race", 12'h100, 32'h1, 1'b0);
      wr("w1c0", 12'h100, 32'h1, 4'hF, 1'b0);
      rd("sticky0_clr", 12'h100, 32'h0, 1'b0);

      // error responses
      wr("err_wr_status", 12'h000, 32'hDEAD_BEEF, 4'hF, 1'b1);
      rd("status0_keep", 12'h000, 32'h0, 1'b0);
      rd("err_rd_oob", 12'(12'h100 + 4 * N_CH), 32'h0, 1'b1);
      wr("err_strb", 12'h304, 32'h0, 4'h3, 1'b1);
      rd("ctrl_keep", 12'h304, 32'h1, 1'b0);
      rd("err_unalign", 12'h002, 32'h0, 1'b1);
      wr("err_wr_irqstat", 12'h300, 32'h0, 4'hF, 1'b1);
      wr("err_mask_strb", 12'h204, 32'h0, 4'h1, 1'b1);
      rd("mask1_keep", 12'h204, 32'hFFFF_0000, 1'b0);

      // re-arm irq and leave PRDATA non-zero before the reset test
      wr("mask1_all", 12'h204, 32'hFFFF_FFFF, 4'hF, 1'b0);
      check("irq_rearm", 32'(irq), 32'h1);
      rd("mask1_all_rb", 12'h204, 32'hFFFF_FFFF, 1'b0);

      // reset during a CTRL write access phase
      status_in = '0;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h304; PWDATA = 32'h1; PSTRB = 4'hF;
      @(posedge clk_in); #1;
      PENABLE = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("mid_prdata", PRDATA, 32'h0);
      check("mid_pready", 32'(PREADY), 32'h0);
      check("mid_pslverr", 32'(PSLVERR), 32'h0);
      check("mid_irq", 32'(irq), 32'h0);
      repeat (2) @(posedge clk_in);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      reset_n = 1'b1;
      @(posedge clk_in); #1;
      rd("ctrl_after_rst", 12'h304, 32'h0, 1'b0);
      rd("mask1_after_rst", 12'h204, 32'hFFFF_FFFF, 1'b0);
      rd("sticky1_after_rst", 12'h104, 32'h0, 1'b0);
      check("irq_after_rst", 32'(irq), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
